data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Parametrised data memory for the 16-bit datapath with a Req/Ready handshake, byte-enable
//  writes, a configurable read pipeline (RD_LAT) and out-of-range error reporting. It clears
//  itself to zero after every reset. Sits between the MEM stage and the register write-back mux.
// PARAMETERS
//  DATA_W  16   word width in bits; must be a multiple of 8
//  ADDR_W  16   address width in bits; addresses are word addresses
//  DEPTH   256  number of words; requires DEPTH <= 2**ADDR_W
//  RD_LAT  1    read latency in clock edges; legal range 1..4
// PORTS
//  Clk         in   1          rising-edge clock
//  Rst_n       in   1          asynchronous, active-low reset
//  Req         in   1          access request; accepted on a rising edge when Req && Ready
//  Ready       out  1          1 when an access can be accepted (RUN state only)
//  MemWrite    in   1          1 = write, 0 = read; qualified by Req
//  Address     in   ADDR_W     word address
//  Write_Data  in   DATA_W     write data
//  Byte_En     in   DATA_W/8   per-byte write enable; bit i enables Write_Data[8i+7:8i]
//  Read_Data   out  DATA_W     read data; holds its last value while Read_Valid=0
//  Read_Valid  out  1          1-cycle pulse per accepted read
//  Err         out  1          1-cycle pulse for an accepted access with Address >= DEPTH
//  Init_Done   out  1          1 once the clear sweep has completed
// BEHAVIOUR
//  Reset (Rst_n=0, asynchronous):
//   - FSM=INIT, clear counter=0, Ready=0, Init_Done=0, Read_Valid=0, Read_Data=0, Err=0.
//   - All in-flight reads are flushed.
//   - The memory array has no reset; its contents are cleared by the INIT sweep.
//  FSM INIT:
//   - Writes 0 to word cnt on each edge, cnt = 0..DEPTH-1.
//   - After the edge that writes word DEPTH-1, moves to RUN. Init_Done=1 and Ready=1 from the
//     next cycle, i.e. exactly DEPTH edges after Rst_n deasserts.
//   - Req is ignored in INIT: no write, no Read_Valid, no Err.
//  FSM RUN:
//   - Ready=1 continuously; one access may be accepted per cycle; no stalls.
//   - Stays in RUN until reset.
//  Write (accepted, MemWrite=1):
//   - At the accept edge, updates only the bytes whose Byte_En bit is set.
//   - Byte_En=0 is a legal no-op.
//   - Produces no Read_Valid.
//  Read (accepted, MemWrite=0):
//   - The array is sampled at the accept edge k.
//   - Read_Data/Read_Valid are driven from the output register after edge k+RD_LAT-1.
//     With RD_LAT=1, data is valid in the cycle immediately after the accept edge.
//   - The pipeline is a shift of {valid, err, data} stages.
//   - Back-to-back reads return one result per cycle, in order.
//  Ordering:
//   - A read accepted at edge k+1 returns data written at edge k (write-then-read returns new
//     data).
//   - A write accepted after a read does not change that read's in-flight result.
//  Out of range (Address >= DEPTH):
//   - Write: array unchanged; Err=1 for the one cycle after the accept edge.
//   - Read: Read_Valid pulses with Read_Data=0; Err pulses in the same cycle as that
//     Read_Valid (RD_LAT-aligned).
//  Address width: only the low clog2(DEPTH) bits index the array, after the range check on the
//   full ADDR_W address.
//  Reset mid-operation: pending Read_Valid/Err pulses are cancelled immediately; none appear
//   after Rst_n is released. INIT restarts from word 0.
// TESTING
//  1. Release reset with DEPTH=256 -> Ready=0 and Init_Done=0 for 256 edges, then both 1;
//     every word reads 0.
//  2. RD_LAT=1: write 0xBEEF to addr 5 with Byte_En=2'b11, then read addr 5 -> Read_Valid=1
//     with 0xBEEF one edge after the read accept.
//  3. Write 0x1234 to addr 5 with Byte_En=2'b01, then read -> 0xBE34. A write with
//     Byte_En=2'b00 -> still 0xBE34, Err=0.
//  4. Write to addr 300 (DEPTH=256) -> Err pulse, no array change. Read addr 300 ->
//     Read_Valid with Read_Data=0 and Err=1 in the same cycle.
//  5. RD_LAT=3: back-to-back reads of addrs 0,1,2 holding 10,11,12 -> Read_Valid high 3
//     consecutive cycles, starting 3 edges after the first accept, data 10,11,12 in order.
//  6. RD_LAT=3: assert Rst_n=0 mid-burst -> Read_Valid=0 immediately, no stale pulse after
//     release. After re-INIT, addr 5 reads 0.

Source files
------------

// File: rtl/data_memory_ctrl_if.sv
// Access bus between the MEM stage (master) and the data memory (slave).
// Requests are qualified by Req && Ready; read results return on Read_Valid.
interface data_memory_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                  Req;
    logic                  Ready;
    logic                  MemWrite;
    logic [ADDR_W-1:0]     Address;
    logic [DATA_W-1:0]     Write_Data;
    logic [DATA_W/8-1:0]   Byte_En;
    logic [DATA_W-1:0]     Read_Data;
    logic                  Read_Valid;
    logic                  Err;
    logic                  Init_Done;

    modport master (
        output Req, MemWrite, Address, Write_Data, Byte_En,
        input  Ready, Read_Data, Read_Valid, Err, Init_Done
    );

    modport slave (
        input  Req, MemWrite, Address, Write_Data, Byte_En,
        output Ready, Read_Data, Read_Valid, Err, Init_Done
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Data memory with byte-enable writes, a zero-clearing sweep after reset and range-checked accesses.
// Reads return RD_LAT edges after accept, one per cycle; Ready=0 only while the clear sweep runs.
module data_memory_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic               Clk,
    input  logic               Rst_n,
    data_memory_ctrl_if.slave  bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state;
    logic [IDX_W-1:0]  cnt;
    logic              acc;
    logic              wr_acc;
    logic              rd_acc;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] err_pipe;
    logic [DATA_W-1:0] dat_pipe [RD_LAT];
    logic              wr_err_q;

    // Range check uses the full address; only then are the low bits used as the index.
    assign in_range = ({1'b0, bus.Address} < DEPTH_A);
    assign idx      = bus.Address[IDX_W-1:0];
    assign acc      = bus.Req && (state == ST_RUN);
    assign wr_acc   = acc && bus.MemWrite;
    assign rd_acc   = acc && !bus.MemWrite;
    assign rd_word  = in_range ? mem[idx] : '0;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
                state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (state == ST_INIT) begin
            mem[cnt] <= '0;
        end else if (wr_acc && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.Byte_En[b]) begin
                    mem[idx][8*b +: 8] <= bus.Write_Data[8*b +: 8];
                end
            end
        end
    end

    // Data stages only load behind a valid so the output holds its last result.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            wr_err_q <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= rd_acc;
            err_pipe[0] <= rd_acc && !in_range;
            if (rd_acc) begin
                dat_pipe[0] <= rd_word;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                err_pipe[i] <= err_pipe[i-1];
                if (vld_pipe[i-1]) begin
                    dat_pipe[i] <= dat_pipe[i-1];
                end
            end
            wr_err_q <= wr_acc && !in_range;
        end
    end

    assign bus.Ready      = (state == ST_RUN);
    assign bus.Init_Done  = (state == ST_RUN);
    assign bus.Read_Valid = vld_pipe[RD_LAT-1];
    assign bus.Read_Data  = dat_pipe[RD_LAT-1];
    assign bus.Err        = err_pipe[RD_LAT-1] | wr_err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Drives an RD_LAT=1 and an RD_LAT=3 instance with identical traffic and checks both
// against a word-array model plus a few hand-computed expectations.
module tb_data_memory_ctrl;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;

    logic clk;
    logic rst_n;
    logic req;
    logic we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    logic [1:0]    be;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    data_memory_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
    data_memory_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus3 ();

    assign bus1.Req        = req;
    assign bus1.MemWrite   = we;
    assign bus1.Address    = addr;
    assign bus1.Write_Data = wdat;
    assign bus1.Byte_En    = be;
    assign bus3.Req        = req;
    assign bus3.MemWrite   = we;
    assign bus3.Address    = addr;
    assign bus3.Write_Data = wdat;
    assign bus3.Byte_En    = be;

    data_memory_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1)) dut1 (
        .Clk(clk), .Rst_n(rst_n), .bus(bus1));
    data_memory_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(3)) dut3 (
        .Clk(clk), .Rst_n(rst_n), .bus(bus3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Reference model: a word array plus, per instance, results due at absolute edge numbers.
    logic [15:0] mmem [DEPTH];
    int          gcur = 0;
    int          ecnt = 0;
    bit          exp_v [2][8];
    bit          exp_e [2][8];
    logic [15:0] exp_d [2][8];
    logic [15:0] hold  [2];
    bit          m_rv  [2];
    bit          m_err [2];
    bit          m_rdy;
    bit          inr;
    int          s;
    int          lat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt  = 0;
            m_rdy = 1'b0;
            for (int d = 0; d < 2; d++) begin
                hold[d]  = '0;
                m_rv[d]  = 1'b0;
                m_err[d] = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    exp_v[d][j] = 1'b0;
                    exp_e[d][j] = 1'b0;
                    exp_d[d][j] = '0;
                end
            end
            for (int w = 0; w < DEPTH; w++) mmem[w] = '0;
        end else begin
            gcur++;
            if (ecnt >= DEPTH && req) begin
                inr = (int'(addr) < DEPTH);
                for (int d = 0; d < 2; d++) begin
                    lat = (d == 0) ? 1 : 3;
                    if (we) begin
                        if (!inr) exp_e[d][gcur % 8] = 1'b1;
                    end else begin
                        s = (gcur + lat - 1) % 8;
                        exp_v[d][s] = 1'b1;
                        if (!inr) exp_e[d][s] = 1'b1;
                        exp_d[d][s] = inr ? mmem[addr] : 16'h0000;
                    end
                end
                if (we && inr) begin
                    for (int b = 0; b < 2; b++)
                        if (be[b]) mmem[addr][8*b +: 8] = wdat[8*b +: 8];
                end
            end
            ecnt++;
            s = gcur % 8;
            for (int d = 0; d < 2; d++) begin
                m_rv[d]  = exp_v[d][s];
                m_err[d] = exp_e[d][s];
                if (m_rv[d]) hold[d] = exp_d[d][s];
                exp_v[d][s] = 1'b0;
                exp_e[d][s] = 1'b0;
            end
            m_rdy = (ecnt >= DEPTH);
        end
    end

    always @(posedge clk) begin
        #3;
        chk1 ("ready_l1", bus1.Ready,      m_rdy);
        chk1 ("init_l1",  bus1.Init_Done,  m_rdy);
        chk1 ("rvalid_l1",bus1.Read_Valid, m_rv[0]);
        chk1 ("err_l1",   bus1.Err,        m_err[0]);
        chk16("rdata_l1", bus1.Read_Data,  hold[0]);
        chk1 ("ready_l3", bus3.Ready,      m_rdy);
        chk1 ("init_l3",  bus3.Init_Done,  m_rdy);
        chk1 ("rvalid_l3",bus3.Read_Valid, m_rv[1]);
        chk1 ("err_l3",   bus3.Err,        m_err[1]);
        chk16("rdata_l3", bus3.Read_Data,  hold[1]);
    end

    // Called at a negedge; applies inputs for the next edge and returns at the following negedge.
    task automatic drive(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [1:0] b);
        req = r; we = w; addr = a; wdat = d; be = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    endtask

    // Called right after Rst_n is released at a negedge.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #3;
            if (bus1.Ready) begin
                n = i;
                break;
            end
        end
        chk16(name, 16'(n), 16'd256);
        @(negedge clk);
    endtask

    task automatic read_lit(input logic [15:0] a, input logic [15:0] e, input logic ee,
                            input string name);
        req = 1'b1; we = 1'b0; addr = a; be = 2'b00;
        @(posedge clk);
        #3;
        chk1 ({name, "_rv1"},  bus1.Read_Valid, 1'b1);
        chk16({name, "_rd1"},  bus1.Read_Data,  e);
        chk1 ({name, "_err1"}, bus1.Err,        ee);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk1 ({name, "_rv3"},  bus3.Read_Valid, 1'b1);
        chk16({name, "_rd3"},  bus3.Read_Data,  e);
        chk1 ({name, "_err3"}, bus3.Err,        ee);
        @(negedge clk);
    endtask

    logic [15:0] ra;

    initial begin
        rst_n = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdat = '0; be = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ready("init_edges");

        for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b0, 16'(a), 16'h0000, 2'b00);
        idle(4);

        drive(1'b1, 1'b1, 16'd5, 16'hBEEF, 2'b11);
        read_lit(16'd5, 16'hBEEF, 1'b0, "full_write");
        drive(1'b1, 1'b1, 16'd5, 16'h1234, 2'b01);
        read_lit(16'd5, 16'hBE34, 1'b0, "low_byte");
        drive(1'b1, 1'b1, 16'd5, 16'hFFFF, 2'b00);
        chk1("be0_err", bus1.Err, 1'b0);
        read_lit(16'd5, 16'hBE34, 1'b0, "be0_noop");
        chk16("model_a5", mmem[5], 16'hBE34);

        drive(1'b1, 1'b1, 16'd300, 16'hAAAA, 2'b11);
        chk1("oor_wr_err", bus1.Err, 1'b1);
        read_lit(16'd300, 16'h0000, 1'b1, "oor_read");
        read_lit(16'd44, 16'h0000, 1'b0, "oor_alias");

        drive(1'b1, 1'b1, 16'd0, 16'd10, 2'b11);
        drive(1'b1, 1'b1, 16'd1, 16'd11, 2'b11);
        drive(1'b1, 1'b1, 16'd2, 16'd12, 2'b11);
        idle(1);
        fork
            begin
                drive(1'b1, 1'b0, 16'd0, 16'h0000, 2'b00);
                drive(1'b1, 1'b0, 16'd1, 16'h0000, 2'b00);
                drive(1'b1, 1'b0, 16'd2, 16'h0000, 2'b00);
                idle(1);
            end
            begin
                @(posedge clk); @(posedge clk); @(posedge clk); #3;
                chk1("burst_v0", bus3.Read_Valid, 1'b1); chk16("burst_d0", bus3.Read_Data, 16'd10);
                @(posedge clk); #3;
                chk1("burst_v1", bus3.Read_Valid, 1'b1); chk16("burst_d1", bus3.Read_Data, 16'd11);
                @(posedge clk); #3;
                chk1("burst_v2", bus3.Read_Valid, 1'b1); chk16("burst_d2", bus3.Read_Data, 16'd12);
                @(posedge clk); #3;
                chk1("burst_end", bus3.Read_Valid, 1'b0); chk16("burst_hold", bus3.Read_Data, 16'd12);
            end
        join
        @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            ra = 16'($urandom_range(0, 299));
            if ($urandom_range(0, 15) == 0) ra = 16'($urandom_range(0, 255)) | 16'h8000;
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra,
                  16'($urandom), 2'($urandom));
        end
        idle(4);

        drive(1'b1, 1'b1, 16'd5, 16'h5A5A, 2'b11);
        drive(1'b1, 1'b0, 16'd5, 16'h0000, 2'b00);
        drive(1'b1, 1'b0, 16'd6, 16'h0000, 2'b00);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        chk1 ("rst_rv3", bus3.Read_Valid, 1'b0);
        chk16("rst_rd3", bus3.Read_Data,  16'h0000);
        chk1 ("rst_rdy", bus1.Ready,      1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready("reinit_edges");
        read_lit(16'd5, 16'h0000, 1'b0, "after_reinit");
        idle(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
